// File: rtl/result_serializer.sv
// ----------------------------------------------------------------------------
// Module   : result_serializer
// Purpose  : Captures the parallel compressor result and shifts it out MSB
//            first on one pin using a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module result_serializer #(
  parameter int WIDTH = 13,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dst,
  input  logic             start,
  input  logic             ready,
  output logic             dst_,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q,  sreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = dst;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // start and dst are deliberately not looked at once a frame is live
        if (ready) begin
          if (cnt_q == C_LAST_IDX) begin
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q + C_CNT_ONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          sreg_d  = dst;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign dst_    = sreg_q[WIDTH-1];
  assign busy    = (state_q == SHIFT);
  assign valid   = busy;
  assign done    = (state_q == DONE);
  assign bit_idx = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_result_serializer.sv
// ----------------------------------------------------------------------------
// Module   : tb_result_serializer
// Purpose  : Randomized and directed scoreboard bench for result_serializer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_result_serializer;

  localparam int WIDTH = 13;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] dst = '0;
  logic             start = 1'b0;
  logic             ready = 1'b0;
  logic             dst_;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a list of bits still owed downstream.
  bit sb[$];
  int m_rem  = 0;
  bit m_done = 1'b0;
  bit sim_end = 1'b0;

  result_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dst(dst), .start(start), .ready(ready),
    .dst_(dst_), .valid(valid), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_rem  = 0;
      m_done = 1'b0;
      sb.delete();
    end else if (m_rem > 0) begin
      m_done = 1'b0;
      if (ready) begin
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_rem = WIDTH;
        sb.delete();
        for (int k = 0; k < WIDTH; k++) sb.push_back(dst[WIDTH-1-k]);
      end
    end
  end

  // Monitor: inputs are stable from posedge+1 until the next posedge.
  always @(negedge clk) begin
    if (!sim_end) begin
      check("valid", {31'd0, valid}, {31'd0, m_rem > 0});
      check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      check("done", {31'd0, done}, {31'd0, m_done});
      if (m_rem > 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got valid frame bit expected none at %0t", $time);
        end else begin
          check("dst_", {31'd0, dst_}, {31'd0, sb[0]});
          check("bit_idx", {28'd0, bit_idx}, 32'(WIDTH - m_rem));
          if (ready && !rst) void'(sb.pop_front());
        end
      end else begin
        check("idle_dst_", {31'd0, dst_}, 32'd0);
        check("idle_bit_idx", {28'd0, bit_idx}, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idx(input int idx);
    int t;
    t = 0;
    while (!(valid && bit_idx == CNT_W'(idx)) && t < 60) begin
      step(1);
      t++;
    end
    if (t >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_idx: got timeout expected bit_idx %0d", idx);
    end
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] v);
    dst   = v;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset with start asserted: nothing may be captured.
    dst   = 13'h1A5B;
    start = 1'b1;
    rst   = 1'b1;
    step(2);
    start = 1'b0;
    rst   = 1'b0;
    step(2);
    check("reset_no_capture", {31'd0, valid}, 32'd0);

    // Basic frame
    ready = 1'b1;
    pulse_start(13'h1A5B);
    step(16);

    // Stall at bit 5
    pulse_start(13'h1A5B);
    wait_idx(5);
    ready = 1'b0;
    step(3);
    check("stall_idx", {28'd0, bit_idx}, 32'd5);
    ready = 1'b1;
    step(12);

    // Mid-frame disturbance
    pulse_start(13'h1A5B);
    wait_idx(3);
    pulse_start(13'h0000);
    step(12);

    // Back-to-back with start held through the done cycle
    dst   = 13'h1FFF;
    start = 1'b1;
    step(1);
    dst = 13'h0001;
    step(15);
    start = 1'b0;
    step(16);

    // Reset mid-frame, then a clean frame
    pulse_start(13'h1A5B);
    wait_idx(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_midframe_valid", {31'd0, valid}, 32'd0);
    step(3);
    pulse_start(13'h1A5B);
    step(16);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      dst   = WIDTH'($urandom);
      start = ($urandom_range(0, 99) < 30);
      ready = ($urandom_range(0, 99) < 70);
      rst   = ($urandom_range(0, 99) < 2);
      step(1);
    end
    rst   = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    step(20);
    check("drained", {31'd0, valid}, 32'd0);

    sim_end = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_serializer.md
# result_serializer

Output-side counterpart of the serial-loading front end around `compressor`. It captures the parallel compressor result `dst0..dst12`, presented as one bus, in a single cycle. It then shifts the captured word out on one pin, MSB first, with a valid/ready handshake. Together with the input shift registers, this lets the compressor be exercised on a narrow-pin test harness.

## Interface
Parameters:
- `WIDTH`, default 13: result width (number of `dst` columns).
- `CNT_W`, default 4: bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `dst`, input, WIDTH: parallel compressor result; bit i corresponds to `dst<i>`.
- `start`, input, 1: capture request, sampled on the rising edge of `clk`.
- `ready`, input, 1: downstream accepts the current serial bit this cycle.
- `dst_`, output, 1: serial data, equal to the shift register MSB.
- `valid`, output, 1: `dst_` holds a frame bit.
- `busy`, output, 1: frame in progress (state SHIFT).
- `done`, output, 1: one-cycle pulse after the last bit is accepted.
- `bit_idx`, output, CNT_W: index of the bit currently on `dst_`, counting from 0 (MSB).

## Operation
- Registers:
  - `sreg[WIDTH-1:0]`
  - `cnt[CNT_W-1:0]`
  - `state` in {IDLE, SHIFT, DONE}
- Outputs, all driven from registered state with no combinational path from inputs:
  - `dst_ = sreg[WIDTH-1]`
  - `valid = busy = (state==SHIFT)`
  - `done = (state==DONE)`
  - `bit_idx = cnt`
- IDLE:
  - `start=1`: `sreg<=dst`, `cnt<=0`, next state SHIFT.
  - otherwise: hold.
- SHIFT:
  - `ready=1` and `cnt!=WIDTH-1`: `sreg<=sreg<<1` (zero fill), `cnt<=cnt+1`.
  - `ready=1` and `cnt==WIDTH-1`: `sreg<=0`, `cnt<=0`, next state DONE.
  - `ready=0`: hold everything (stall of any length).
  - `start` is ignored in SHIFT; `dst` changes are ignored after capture.
- DONE, lasting exactly one cycle:
  - `start=1`: capture as in IDLE, next state SHIFT (back-to-back frames).
  - otherwise: next state IDLE.
- Bit order: frame bit k, for k = 0..WIDTH-1, equals captured `dst[WIDTH-1-k]`. This mirrors the input shift registers, where the first serial bit in lands at the MSB.
- `rst=1` in any state, including mid-frame: on that edge `state<=IDLE`, `sreg<=0`, `cnt<=0`. The frame is abandoned and `done` is not pulsed. `rst` has priority over `start`.

## Timing
- Reset values: `dst_=0`, `valid=0`, `busy=0`, `done=0`, `bit_idx=0`.
- Capture latency: `start` high at edge N means `valid=1` and `dst_=dst[WIDTH-1]` (the value sampled at edge N) from N+1.
- Transfer: a bit is accepted on an edge where `valid & ready`. The next bit appears after that edge.
- Minimum frame length with `ready` held high: WIDTH cycles with `valid=1`, followed by one `done` cycle.
- Back-to-back with `start` held high and `ready` high: period WIDTH+1 cycles. `valid` drops only during the `done` cycle.
- Stall: while `ready=0`, `dst_`, `bit_idx` and `valid` are stable.
- `done` is never high at the same time as `valid`.

## Test plan
- Reset: assert `rst` for 2 cycles with `start=1` -> `valid=0`, `done=0`, `dst_=0`, `bit_idx=0`; no capture.
- Basic frame: `dst=13'h1A5B`, pulse `start`, `ready=1` -> `dst_` sequence 1,1,0,1,0,0,1,0,1,1,0,1,1 over 13 cycles with `bit_idx` 0..12, then `done=1` for 1 cycle, then IDLE.
- Stall: same frame, `ready=0` for 3 cycles at `bit_idx=5` -> `dst_=0` and `bit_idx=5` held for 3 cycles; frame completes in 16 valid cycles with an unchanged sequence.
- Mid-frame disturbance: change `dst` to 13'h0000 and pulse `start` at `bit_idx=3` -> sequence unchanged (still 13'h1A5B), no restart.
- Back-to-back: `dst=13'h1FFF`, then `dst=13'h0001`, with `start` high in the `done` cycle -> 13 ones, 1 `done` cycle, then 12 zeros followed by a single 1; period 14 cycles.
- Reset mid-frame: `rst` at `bit_idx=7` -> next cycle `valid=0`, `done` never pulses; a subsequent `start` with 13'h1A5B produces a correct full frame.
